// File: rtl/sum_block_accum_pkg.sv
// Shared types for the sum block accumulator.
// State encoding used by the control FSM.
package sum_block_accum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DUMP  = 2'd2
    } state_t;

endpackage

// File: rtl/sum_block_accum_add.sv
// Registered accumulator adder with clear, enable and carry-out.
// sum/cout show the result the next enabled edge will store.
module acc_add_reg
    import sum_block_accum_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] addend,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH-1:0] acc;

    assign {cout, sum} = {1'b0, acc} + {1'b0, addend};

    // Clear wins over enable so a block restart never mixes in a sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/sum_block_accum.sv
// Accumulates NUM_SAMPLES valid adder sums per block and
// hands the total out over a valid/ready handshake.
module sum_block_accum
    import sum_block_accum_pkg::*;
#(
    parameter int SUM_WIDTH    = 57,
    parameter int NUM_SAMPLES  = 16,
    parameter int ACC_WIDTH    = 64,
    parameter int CNT_WIDTH    = 5,
    parameter int AUTO_RESTART = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [SUM_WIDTH-1:0] sum_in,
    input  logic                 sum_valid,
    output logic [ACC_WIDTH-1:0] acc_out,
    output logic                 acc_valid,
    input  logic                 acc_ready,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 overflow,
    output logic                 dropped
);

    localparam logic [CNT_WIDTH-1:0] LAST =
        CNT_WIDTH'(NUM_SAMPLES - 1);
    localparam bit AUTO = (AUTO_RESTART != 0);

    state_t               state;
    logic                 hs;
    logic                 add_en;
    logic                 add_clr;
    logic [ACC_WIDTH-1:0] addend;
    logic [ACC_WIDTH-1:0] add_sum;
    logic                 add_cout;

    assign hs      = acc_valid & acc_ready;
    assign add_en  = (state == ACCUM) & sum_valid;
    assign add_clr = ((state == IDLE) & start) |
                     ((state == DUMP) & hs & AUTO);
    assign addend  = ACC_WIDTH'(sum_in);
    assign busy    = (state != IDLE);

    acc_add_reg #(
        .WIDTH (ACC_WIDTH)
    ) u_add (
        .clk    (clk),
        .rst    (rst),
        .clr    (add_clr),
        .en     (add_en),
        .addend (addend),
        .sum    (add_sum),
        .cout   (add_cout)
    );

    // Block control: counter, sticky flags and result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            acc_out   <= '0;
            acc_valid <= 1'b0;
            overflow  <= 1'b0;
            dropped   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state    <= ACCUM;
                        count    <= '0;
                        overflow <= 1'b0;
                        dropped  <= 1'b0;
                    end
                end
                ACCUM: begin
                    if (sum_valid) begin
                        count <= count + CNT_WIDTH'(1);
                        if (add_cout) begin
                            overflow <= 1'b1;
                        end
                        if (count == LAST) begin
                            acc_out   <= add_sum;
                            acc_valid <= 1'b1;
                            state     <= DUMP;
                        end
                    end
                end
                DUMP: begin
                    if (hs) begin
                        acc_valid <= 1'b0;
                        if (AUTO) begin
                            state    <= ACCUM;
                            count    <= '0;
                            overflow <= 1'b0;
                            dropped  <= 1'b0;
                        end else begin
                            state <= IDLE;
                            if (sum_valid) begin
                                dropped <= 1'b1;
                            end
                        end
                    end else if (sum_valid) begin
                        dropped <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sum_block_accum.sv
// Directed bench for sum_block_accum: default, 58-bit and
// auto-restart builds share one stimulus bus.
module tb_sum_block_accum;

    localparam logic [56:0] MAX57 = {57{1'b1}};

    logic        clk;
    logic        rst;
    logic        start;
    logic [56:0] sum_in;
    logic        sum_valid;
    logic        acc_ready;

    logic [63:0] acc_out0;
    logic        acc_valid0, busy0, overflow0, dropped0;
    logic [4:0]  count0;

    logic [57:0] acc_outv;
    logic        acc_validv, busyv, overflowv, droppedv;
    logic [4:0]  countv;

    logic [63:0] acc_outa;
    logic        acc_valida, busya, overflowa, droppeda;
    logic [4:0]  counta;

    int passed = 0;
    int total  = 0;

    sum_block_accum dut0 (
        .clk(clk), .rst(rst), .start(start),
        .sum_in(sum_in), .sum_valid(sum_valid),
        .acc_out(acc_out0), .acc_valid(acc_valid0),
        .acc_ready(acc_ready), .busy(busy0),
        .count(count0), .overflow(overflow0),
        .dropped(dropped0)
    );

    sum_block_accum #(.ACC_WIDTH(58)) dutv (
        .clk(clk), .rst(rst), .start(start),
        .sum_in(sum_in), .sum_valid(sum_valid),
        .acc_out(acc_outv), .acc_valid(acc_validv),
        .acc_ready(acc_ready), .busy(busyv),
        .count(countv), .overflow(overflowv),
        .dropped(droppedv)
    );

    sum_block_accum #(.AUTO_RESTART(1)) duta (
        .clk(clk), .rst(rst), .start(start),
        .sum_in(sum_in), .sum_valid(sum_valid),
        .acc_out(acc_outa), .acc_valid(acc_valida),
        .acc_ready(acc_ready), .busy(busya),
        .count(counta), .overflow(overflowa),
        .dropped(droppeda)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        sum_valid = 1'b0;
        sum_in = '0;
        acc_ready = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic start_block();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({acc_out0, acc_valid0, busy0, count0,
             overflow0, dropped0} !== '0)
            $display("FAIL reset_outputs got %h/%b/%b/%0d/%b/%b want 0",
                     acc_out0, acc_valid0, busy0, count0,
                     overflow0, dropped0);
        else passed++;
        sum_valid = 1'b1;
        sum_in = 57'd7;
        tick();
        sum_valid = 1'b0;
        total++;
        if (dropped0 !== 1'b0 || count0 !== 5'd0 || busy0 !== 1'b0)
            $display("FAIL idle_ignore got drop=%b cnt=%0d busy=%b want 0/0/0",
                     dropped0, count0, busy0);
        else passed++;
    endtask

    task automatic test_basic();
        do_reset();
        start_block();
        total++;
        if (busy0 !== 1'b1)
            $display("FAIL basic_busy got %b want 1", busy0);
        else passed++;
        for (int i = 1; i <= 16; i++) begin
            sum_in = 57'(i);
            sum_valid = 1'b1;
            tick();
            if (i == 15) begin
                total++;
                if (acc_valid0 !== 1'b0 || count0 !== 5'd15)
                    $display("FAIL basic_early got v=%b cnt=%0d want 0/15",
                             acc_valid0, count0);
                else passed++;
            end
        end
        sum_valid = 1'b0;
        total++;
        if (acc_valid0 !== 1'b1 || acc_out0 !== 64'd136 ||
            count0 !== 5'd16 || overflow0 !== 1'b0)
            $display("FAIL basic_result got v=%b out=%0d cnt=%0d ov=%b want 1/136/16/0",
                     acc_valid0, acc_out0, count0, overflow0);
        else passed++;
        tick();
        total++;
        if (acc_valid0 !== 1'b0 || busy0 !== 1'b0)
            $display("FAIL basic_idle got v=%b busy=%b want 0/0",
                     acc_valid0, busy0);
        else passed++;
    endtask

    task automatic test_gapped();
        do_reset();
        start_block();
        for (int k = 1; k <= 16; k++) begin
            sum_in = MAX57;
            sum_valid = 1'b1;
            tick();
            sum_valid = 1'b0;
            if (k == 16) begin
                total++;
                if (acc_valid0 !== 1'b1 ||
                    acc_out0 !== 64'h1FFF_FFFF_FFFF_FFF0 ||
                    overflow0 !== 1'b0)
                    $display("FAIL gap_result got v=%b out=%h ov=%b want 1/1ffffffffffffff0/0",
                             acc_valid0, acc_out0, overflow0);
                else passed++;
            end
            tick();
            if (k == 5 || k == 11) begin
                total++;
                if (count0 !== 5'(k))
                    $display("FAIL gap_count got %0d want %0d", count0, k);
                else passed++;
            end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        start_block();
        for (int i = 0; i < 16; i++) begin
            sum_in = MAX57;
            sum_valid = 1'b1;
            tick();
        end
        sum_valid = 1'b0;
        total++;
        if (acc_validv !== 1'b1 ||
            acc_outv !== 58'h3FF_FFFF_FFFF_FFF0 ||
            overflowv !== 1'b1)
            $display("FAIL ovf_result got v=%b out=%h ov=%b want 1/3fffffffffffff0/1",
                     acc_validv, acc_outv, overflowv);
        else passed++;
        tick();
        total++;
        if (overflowv !== 1'b1 || busyv !== 1'b0)
            $display("FAIL ovf_hold got ov=%b busy=%b want 1/0",
                     overflowv, busyv);
        else passed++;
        start_block();
        total++;
        if (overflowv !== 1'b0 || countv !== 5'd0)
            $display("FAIL ovf_clear got ov=%b cnt=%0d want 0/0",
                     overflowv, countv);
        else passed++;
    endtask

    task automatic test_backpressure();
        do_reset();
        acc_ready = 1'b0;
        start_block();
        for (int i = 0; i < 16; i++) begin
            sum_in = 57'd5;
            sum_valid = 1'b1;
            tick();
        end
        sum_in = 57'd100;
        for (int c = 1; c <= 5; c++) begin
            tick();
            total++;
            if (acc_valid0 !== 1'b1 || acc_out0 !== 64'd80 ||
                dropped0 !== 1'b1)
                $display("FAIL bp_hold%0d got v=%b out=%0d drop=%b want 1/80/1",
                         c, acc_valid0, acc_out0, dropped0);
            else passed++;
        end
        acc_ready = 1'b1;
        sum_valid = 1'b0;
        tick();
        total++;
        if (acc_valid0 !== 1'b0 || busy0 !== 1'b0 ||
            dropped0 !== 1'b1)
            $display("FAIL bp_accept got v=%b busy=%b drop=%b want 0/0/1",
                     acc_valid0, busy0, dropped0);
        else passed++;
    endtask

    task automatic test_auto_restart();
        do_reset();
        start_block();
        sum_in = 57'd3;
        sum_valid = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        total++;
        if (acc_valida !== 1'b1 || acc_outa !== 64'd48)
            $display("FAIL auto_blk1 got v=%b out=%0d want 1/48",
                     acc_valida, acc_outa);
        else passed++;
        tick();
        total++;
        if (acc_valida !== 1'b0 || busya !== 1'b1 ||
            counta !== 5'd0 || droppeda !== 1'b0)
            $display("FAIL auto_restart got v=%b busy=%b cnt=%0d drop=%b want 0/1/0/0",
                     acc_valida, busya, counta, droppeda);
        else passed++;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i == 15) begin
                total++;
                if (acc_valida !== 1'b0 || counta !== 5'd15)
                    $display("FAIL auto_excl got v=%b cnt=%0d want 0/15",
                             acc_valida, counta);
                else passed++;
            end
        end
        sum_valid = 1'b0;
        total++;
        if (acc_valida !== 1'b1 || acc_outa !== 64'd48 ||
            droppeda !== 1'b0)
            $display("FAIL auto_blk2 got v=%b out=%0d drop=%b want 1/48/0",
                     acc_valida, acc_outa, droppeda);
        else passed++;
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        start_block();
        sum_in = 57'd9;
        sum_valid = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        sum_valid = 1'b0;
        total++;
        if (count0 !== 5'd7 || busy0 !== 1'b1)
            $display("FAIL mid_pre got cnt=%0d busy=%b want 7/1",
                     count0, busy0);
        else passed++;
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({acc_out0, acc_valid0, busy0, count0,
             overflow0, dropped0} !== '0)
            $display("FAIL mid_async got out=%0d v=%b busy=%b cnt=%0d want 0",
                     acc_out0, acc_valid0, busy0, count0);
        else passed++;
        #1;
        rst = 1'b0;
        tick();
        start_block();
        sum_in = 57'd2;
        sum_valid = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        sum_valid = 1'b0;
        total++;
        if (acc_valid0 !== 1'b1 || acc_out0 !== 64'd32)
            $display("FAIL mid_after got v=%b out=%0d want 1/32",
                     acc_valid0, acc_out0);
        else passed++;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        sum_in = '0;
        sum_valid = 1'b0;
        acc_ready = 1'b1;
        test_reset();
        test_basic();
        test_gapped();
        test_overflow();
        test_backpressure();
        test_auto_restart();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
